// File: rtl/timer_bcd_countdown_pkg.sv
// rtl/timer_bcd_countdown_pkg.sv - state encoding and BCD limits shared by the countdown timer
package timer_bcd_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   // Keypad entry may leave 6..9 in the seconds-tens slot; counting needs 0..5.
   function automatic logic [3:0] clamp_tens(input logic [3:0] d);
      return (d > SEC_TENS_MAX) ? SEC_TENS_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with borrow chain and parallel load
module bcd_down_digit
   import timer_bcd_countdown_pkg::*;
#(
   parameter logic [3:0] MAXV = BCD_MAX
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   input  logic       borrow_in,
   output logic [3:0] q,
   output logic       borrow_out,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= 4'd0;
      end else if (load) begin
         q <= load_val;
      end else if (dec && borrow_in) begin
         q <= (q == 4'd0) ? MAXV : q - 4'd1;
      end
   end

   assign is_zero    = (q == 4'd0);
   assign borrow_out = is_zero & borrow_in;

endmodule

// File: rtl/timer_bcd_countdown.sv
// rtl/timer_bcd_countdown.sv - BCD min:sec countdown timer; alarm output enabled by TIMER_ALARM_EN
module timer_bcd_countdown
   import timer_bcd_countdown_pkg::*;
#(
   parameter int MIN_DIGITS = 1
`ifdef TIMER_ALARM_EN
  ,parameter int ALARM_TICKS = 3
`endif
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    tick,
   input  logic                    key_valid,
   input  logic [3:0]              key_data,
   input  logic                    start,
   input  logic                    stop,
   output logic [3:0]              sec_units,
   output logic [3:0]              sec_tens,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic                    zero,
   output logic                    running,
   output logic                    done
`ifdef TIMER_ALARM_EN
  ,output logic                    alarm
`endif
);

   localparam int ND = 2 + MIN_DIGITS;
   localparam int W  = 4 * ND;

   state_t         state, state_nxt;
   logic [W-1:0]   digits;
   logic [W-1:0]   load_val;
   logic [W-1:0]   shifted;
   logic [ND-1:0]  is_z;
   logic [ND:0]    borrow;
   logic           load;
   logic           dec;
   logic           expire;
   logic           key_ok;
   logic           last_sec;

   assign borrow[0] = 1'b1;

   // Digit 0 is seconds units, digit 1 seconds tens, the rest are minutes.
   for (genvar i = 0; i < ND; i++) begin : g_digit
      localparam logic [3:0] MAXV_I = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
      bcd_down_digit #(.MAXV(MAXV_I)) u_digit (
         .clk        (clk),
         .clear      (clear),
         .load       (load),
         .load_val   (load_val[4*i +: 4]),
         .dec        (dec),
         .borrow_in  (borrow[i]),
         .q          (digits[4*i +: 4]),
         .borrow_out (borrow[i+1]),
         .is_zero    (is_z[i])
      );
   end

   assign zero      = borrow[ND];
   assign sec_units = digits[3:0];
   assign sec_tens  = digits[7:4];
   assign minutes   = digits[W-1:8];
   assign running   = (state == ST_RUN);

   assign key_ok   = key_valid && (key_data <= BCD_MAX);
   assign shifted  = {digits[W-5:0], key_data};
   // Value is exactly 0:01, so the next decrement reaches zero.
   assign last_sec = !is_z[0] && (digits[3:1] == 3'd0) && (&is_z[ND-1:1]);

   always_ff @(posedge clk) begin
      if (clear) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= expire;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_val  = digits;
      dec       = 1'b0;
      expire    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (stop) begin
               load     = 1'b1;
               load_val = '0;
            end else if (start && !zero) begin
               state_nxt     = ST_RUN;
               load          = 1'b1;
               load_val[7:4] = clamp_tens(digits[7:4]);
            end else if (key_ok) begin
               load     = 1'b1;
               load_val = shifted;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_nxt = ST_PAUSE;
            end else if (tick) begin
               dec = 1'b1;
               if (last_sec) begin
                  expire    = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               load      = 1'b1;
               load_val  = '0;
            end else if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               load      = 1'b1;
               load_val  = '0;
            end else if (key_valid) begin
               state_nxt = ST_IDLE;
               load      = 1'b1;
               load_val  = key_ok ? {{(W-4){1'b0}}, key_data} : '0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef TIMER_ALARM_EN
   localparam int AW = $clog2(ALARM_TICKS + 1);
   logic [AW-1:0] alarm_cnt;

   always_ff @(posedge clk) begin
      if (clear) begin
         alarm     <= 1'b0;
         alarm_cnt <= '0;
      end else if (expire) begin
         alarm     <= 1'b1;
         alarm_cnt <= '0;
      end else if (alarm && (stop || key_valid)) begin
         alarm <= 1'b0;
      end else if (alarm && tick) begin
         alarm_cnt <= alarm_cnt + AW'(1);
         if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
            alarm <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_timer_bcd_countdown.sv
// tb/tb_timer_bcd_countdown.sv - directed and random checks of two timer widths against a seconds-based model
module tb_timer_bcd_countdown;

   localparam int AT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clear = 1'b0, tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0;
   logic [3:0] key_data = 4'd0;

   logic [3:0] su1, st1, m1, su2, st2;
   logic [7:0] m2;
   logic       z1, r1, d1, z2, r2, d2;
`ifdef TIMER_ALARM_EN
   logic       a1, a2;
`endif

   timer_bcd_countdown #(.MIN_DIGITS(1)) u1 (
      .clk(clk), .clear(clear), .tick(tick), .key_valid(key_valid), .key_data(key_data),
      .start(start), .stop(stop), .sec_units(su1), .sec_tens(st1), .minutes(m1),
      .zero(z1), .running(r1), .done(d1)
`ifdef TIMER_ALARM_EN
     ,.alarm(a1)
`endif
   );

   timer_bcd_countdown #(.MIN_DIGITS(2)) u2 (
      .clk(clk), .clear(clear), .tick(tick), .key_valid(key_valid), .key_data(key_data),
      .start(start), .stop(stop), .sec_units(su2), .sec_tens(st2), .minutes(m2),
      .zero(z2), .running(r2), .done(d2)
`ifdef TIMER_ALARM_EN
     ,.alarm(a2)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: IDLE holds the typed entry as a decimal number; otherwise whole seconds remain.
   int m_mode[2];
   int m_val[2];
   int m_done[2];
   int m_alarm[2];
   int m_acnt[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int n);
      logic [31:0] r = '0;
      int v = n;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int disp_dec(input int i);
      if (m_mode[i] == 0) return m_val[i];
      return (m_val[i] / 60) * 100 + m_val[i] % 60;
   endfunction

   task automatic model_step(input int i, input bit c, input bit t, input bit kv,
                             input logic [3:0] kd, input bit s, input bit p);
      int tens;
      bit exp_now = 1'b0;
      int lim = (i == 0) ? 1000 : 10000;
      m_done[i] = 0;
      if (c) begin
         m_mode[i] = 0; m_val[i] = 0; m_alarm[i] = 0; m_acnt[i] = 0;
         return;
      end
      case (m_mode[i])
         0: begin
            if (p) m_val[i] = 0;
            else if (s && m_val[i] != 0) begin
               tens = (m_val[i] / 10) % 10;
               if (tens > 5) tens = 5;
               m_val[i]  = (m_val[i] / 100) * 60 + tens * 10 + m_val[i] % 10;
               m_mode[i] = 1;
            end else if (kv && kd <= 9) m_val[i] = (m_val[i] * 10 + int'(kd)) % lim;
         end
         1: begin
            if (p) m_mode[i] = 2;
            else if (t) begin
               m_val[i]--;
               if (m_val[i] == 0) begin
                  m_mode[i] = 3; m_done[i] = 1; exp_now = 1'b1;
               end
            end
         end
         2: begin
            if (p) begin m_mode[i] = 0; m_val[i] = 0; end
            else if (s) m_mode[i] = 1;
         end
         default: begin
            if (p) begin m_mode[i] = 0; m_val[i] = 0; end
            else if (kv) begin m_mode[i] = 0; m_val[i] = (kd <= 9) ? int'(kd) : 0; end
         end
      endcase
      if (exp_now) begin
         m_alarm[i] = 1; m_acnt[i] = 0;
      end else if (m_alarm[i] != 0 && (p || kv)) begin
         m_alarm[i] = 0;
      end else if (m_alarm[i] != 0 && t) begin
         m_acnt[i]++;
         if (m_acnt[i] == AT) m_alarm[i] = 0;
      end
   endtask

   task automatic check_all();
      check("u1_digits",  {20'd0, m1, st1, su1}, to_bcd(disp_dec(0)));
      check("u1_zero",    32'(z1), 32'(disp_dec(0) == 0));
      check("u1_running", 32'(r1), 32'(m_mode[0] == 1));
      check("u1_done",    32'(d1), 32'(m_done[0]));
      check("u2_digits",  {16'd0, m2, st2, su2}, to_bcd(disp_dec(1)));
      check("u2_zero",    32'(z2), 32'(disp_dec(1) == 0));
      check("u2_running", 32'(r2), 32'(m_mode[1] == 1));
      check("u2_done",    32'(d2), 32'(m_done[1]));
`ifdef TIMER_ALARM_EN
      check("u1_alarm",   32'(a1), 32'(m_alarm[0]));
      check("u2_alarm",   32'(a2), 32'(m_alarm[1]));
`endif
   endtask

   task automatic step(input bit c, input bit t, input bit kv, input logic [3:0] kd,
                       input bit s, input bit p);
      clear = c; tick = t; key_valid = kv; key_data = kd; start = s; stop = p;
      @(posedge clk);
      model_step(0, c, t, kv, kd, s, p);
      model_step(1, c, t, kv, kd, s, p);
      #1;
      clear = 0; tick = 0; key_valid = 0; start = 0; stop = 0;
      check_all();
   endtask

   task automatic press(input logic [3:0] k); step(0, 0, 1, k, 0, 0); endtask
   task automatic tk();                       step(0, 1, 0, 4'd0, 0, 0); endtask
   task automatic go();                       step(0, 0, 0, 4'd0, 1, 0); endtask
   task automatic halt();                     step(0, 0, 0, 4'd0, 0, 1); endtask
   task automatic rst();                      step(1, 0, 0, 4'd0, 0, 0); endtask

   initial begin
      int dcount;
      #1;
      rst();
      check("reset_u1", {20'd0, m1, st1, su1}, 32'h0);
      check("reset_u2_run", 32'(r2), 32'd0);

      // 1:30 down to expiry with one done pulse
      press(1); press(3); press(0);
      check("t1_preset", {20'd0, m1, st1, su1}, 32'h130);
      go();
      dcount = 0;
      for (int n = 0; n < 130; n++) begin
         tk();
         if (d1) dcount++;
      end
      check("t1_done_count", 32'(dcount), 32'd1);
      check("t1_zero", 32'(z1), 32'd1);

      // borrow across tens and minutes
      halt(); press(1); press(0); press(0); go(); tk();
      check("t2_u1_059", {20'd0, m1, st1, su1}, 32'h059);
      check("t2_u2_0059", {16'd0, m2, st2, su2}, 32'h0059);
      rst(); press(1); press(0); press(0); press(0); go(); tk();
      check("t2_u2_0959", {16'd0, m2, st2, su2}, 32'h0959);
      check("t2_u1_idle", 32'(r1), 32'd0);

      // clamp, MS discard, invalid key
      rst(); press(9); press(9); go();
      check("t3_clamp", {20'd0, m1, st1, su1}, 32'h059);
      rst(); press(1); press(2); press(3); press(4); press(4'hA);
      check("t3_discard", {20'd0, m1, st1, su1}, 32'h234);
      check("t3_u2_keep", {16'd0, m2, st2, su2}, 32'h1234);

      // pause, resume, cancel
      rst(); press(4); press(5); go(); halt();
      repeat (5) tk();
      check("t4_hold", {20'd0, m1, st1, su1}, 32'h045);
      go(); tk();
      check("t4_044", {20'd0, m1, st1, su1}, 32'h044);
      halt(); halt();
      check("t4_cancel", {20'd0, m1, st1, su1}, 32'h000);

      // edge cases
      go();
      check("t5_start_zero", 32'(r1), 32'd0);
      press(3); press(1); press(2); go();
      step(0, 1, 0, 4'd0, 1, 1);
      check("t5_stop_beats", 32'(r1), 32'd0);
      go(); tk();
      rst();
      check("t5_clear", {20'd0, m1, st1, su1}, 32'h000);

`ifdef TIMER_ALARM_EN
      press(2); go(); tk(); tk();
      check("t6_alarm_on", 32'(a1), 32'd1);
      tk(); tk();
      check("t6_alarm_2t", 32'(a1), 32'd1);
      tk();
      check("t6_alarm_off", 32'(a1), 32'd0);
      press(5); go(); repeat (5) tk();
      press(7);
      check("t6_alarm_key", 32'(a1), 32'd0);
`endif

      // random traffic
      rst();
      for (int n = 0; n < 4000; n++) begin
         int r = $urandom_range(0, 9);
         bit c = ($urandom_range(0, 299) == 0);
         bit t = ($urandom_range(0, 2) == 0);
         logic [3:0] kd = 4'($urandom_range(0, 11));
         step(c, t, r < 3, kd, r == 3 || r == 5, r == 4 || r == 5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
